// File: rtl/lc_transition_initiator_pkg.sv
// Shared types and constants for the lifecycle transition initiator: status
// codes, lifecycle state encodings and the initiator FSM state type.
package lc_pkg;

  localparam int LC_STATE_W = 3;
  localparam logic [LC_STATE_W-1:0] LC_RESET_STATE = 3'b001;
  localparam logic [LC_STATE_W-1:0] LC_EOL         = 3'd5;

  typedef enum logic [2:0] {
    STATUS_NONE           = 3'd0,
    STATUS_OK             = 3'd1,
    STATUS_REJECTED       = 3'd2,
    STATUS_TIMEOUT        = 3'd3,
    STATUS_INCOMPLETE     = 3'd4,
    STATUS_EOL            = 3'd5,
    STATUS_STATE_MISMATCH = 3'd6
  } lc_status_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_RELEASE,
    S_REPORT
  } init_state_t;

endpackage

// File: rtl/lc_transition_initiator_if.sv
// Request/identifier handshake between the transition initiator (master)
// and lifecycle_protection (slave).
interface lc_transition_initiator_if #(
  parameter int ID_W = 256
);
  import lc_pkg::*;

  logic                  lc_transition_request;
  logic [ID_W-1:0]       lc_identifier;
  logic                  lc_success;
  logic                  lc_done;
  logic [LC_STATE_W-1:0] lc_state;

  modport master (
    output lc_transition_request,
    output lc_identifier,
    input  lc_success,
    input  lc_done,
    input  lc_state
  );

  modport slave (
    input  lc_transition_request,
    input  lc_identifier,
    output lc_success,
    output lc_done,
    output lc_state
  );

endinterface

// File: rtl/lc_id_assembler.sv
// Assembles the owner identifier from host words, least significant word
// first; the buffer holds secret material and is zeroized on clear and reset.
module lc_id_assembler #(
  parameter int WORD_W = 32,
  parameter int ID_W   = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              clear,
  output logic              full,
  output logic [ID_W-1:0]   id
);

  localparam int NWORDS = ID_W / WORD_W;
  localparam int CNT_W  = $clog2(NWORDS + 1);

  logic [CNT_W-1:0] count;

  assign full     = (count == CNT_W'(NWORDS));
  assign wr_ready = !full;

  // NOTE: the identifier buffer is reset like any control register because
  // an aborted attempt must never leave owner material behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      id    <= '0;
    end else if (clear) begin
      count <= '0;
      id    <= '0;
    end else if (wr_valid && wr_ready) begin
      for (int k = 0; k < NWORDS; k++) begin
        if (count == CNT_W'(k)) id[k*WORD_W +: WORD_W] <= wr_data;
      end
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lc_transition_initiator.sv
// Requester-side lifecycle transition controller: collects the owner id,
// runs the request/done handshake and reports a one-cycle status pulse.
module lc_transition_initiator
  import lc_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int ID_W           = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_word_valid,
  output logic                      id_word_ready,
  input  logic [WORD_W-1:0]         id_word_data,
  input  logic                      start,
  output logic                      busy,
  output logic                      cmd_done,
  output lc_status_t                cmd_status,
  lc_transition_initiator_if.master lc_if
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

  init_state_t           state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d, timer_inc;
  logic [LC_STATE_W-1:0] pre_state_q, pre_state_d;
  logic                  success_q, success_d;
  lc_status_t            status_q, status_d;
  logic                  timeout_hit;

  logic            asm_ready;
  logic            asm_full;
  logic            asm_valid;
  logic [ID_W-1:0] id_buf;

  lc_id_assembler #(
    .WORD_W (WORD_W),
    .ID_W   (ID_W)
  ) u_assembler (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (asm_valid),
    .wr_ready (asm_ready),
    .wr_data  (id_word_data),
    .clear    (state_q == S_REPORT),
    .full     (asm_full),
    .id       (id_buf)
  );

  // start wins over a word offered in the same cycle.
  assign id_word_ready = (state_q == S_IDLE) && !start && asm_ready;
  assign asm_valid     = id_word_valid && id_word_ready;

  // timeout_hit marks the edge on which the timer reaches the limit, so the
  // request is held for exactly TIMEOUT_CYCLES cycles before it is abandoned.
  assign timer_inc   = (timer_q == TMR_LIMIT) ? timer_q : timer_q + TMR_W'(1);
  assign timeout_hit = (timer_inc == TMR_LIMIT);

  // NOTE: every signal gets a default first so no path through the case
  // statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pre_state_d = pre_state_q;
    success_d   = success_q;
    status_d    = status_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!asm_full) begin
            status_d = STATUS_INCOMPLETE;
            state_d  = S_REPORT;
          end else if (lc_if.lc_state >= LC_EOL) begin
            status_d = STATUS_EOL;
            state_d  = S_REPORT;
          end else begin
            pre_state_d = lc_if.lc_state;
            timer_d     = '0;
            status_d    = STATUS_NONE;
            state_d     = S_REQUEST;
          end
        end
      end
      S_REQUEST: begin
        timer_d = timer_inc;
        if (timeout_hit) begin
          status_d = STATUS_TIMEOUT;
          state_d  = S_REPORT;
        end else if (lc_if.lc_done) begin
          success_d = lc_if.lc_success;
          state_d   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        timer_d = timer_inc;
        if (timeout_hit) begin
          status_d = STATUS_TIMEOUT;
          state_d  = S_REPORT;
        end else if (!lc_if.lc_done) begin
          if (!success_q)                                        status_d = STATUS_REJECTED;
          else if (lc_if.lc_state == pre_state_q + LC_STATE_W'(1)) status_d = STATUS_OK;
          else                                                    status_d = STATUS_STATE_MISMATCH;
          state_d = S_REPORT;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      pre_state_q <= LC_RESET_STATE;
      success_q   <= 1'b0;
      status_q    <= STATUS_NONE;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pre_state_q <= pre_state_d;
      success_q   <= success_d;
      status_q    <= status_d;
    end
  end

  assign busy                        = (state_q != S_IDLE);
  assign cmd_done                    = (state_q == S_REPORT);
  assign cmd_status                  = status_q;
  assign lc_if.lc_transition_request = (state_q == S_REQUEST);
  assign lc_if.lc_identifier         = (state_q == S_REQUEST) ? id_buf : '0;

endmodule

// File: doc/lc_transition_initiator.md
Name: lc_transition_initiator

Overview:
Requester-side controller for the lifecycle transition handshake. It takes a 256-bit owner identifier from a host as eight 32-bit words and drives the request/identifier pair into lifecycle_protection. It holds the request until done, releases it, and waits for done to drop. It then reports a one-cycle completion with a status code, and zeroizes the identifier buffer after every attempt.

Parameters:
WORD_W, 32, host word width; ID_W must be a multiple of WORD_W
ID_W, 256, identifier width (NWORDS = ID_W/WORD_W = 8)
TIMEOUT_CYCLES, 1024, maximum cycles spent in REQUEST+RELEASE before aborting

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
id_word_valid  in  1  host word valid
id_word_ready  out  1  word accepted when valid&&ready
id_word_data  in  WORD_W  identifier word; word k fills bits [WORD_W*k +: WORD_W], word 0 least significant
start  in  1  single-cycle command pulse
busy  out  1  high in REQUEST, RELEASE, REPORT
cmd_done  out  1  one-cycle completion pulse
cmd_status  out  3  result; valid while cmd_done=1 and held until next start
lc_transition_request  out  1  to responder
lc_identifier  out  ID_W  to responder
lc_success  in  1  from responder
lc_done  in  1  from responder
lc_state  in  3  current lifecycle state from responder

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; word count=0; buffer=0.
- Output reset values: lc_transition_request=0, lc_identifier=0, cmd_done=0, cmd_status=NONE, busy=0, timer=0.
- States: IDLE, REQUEST, RELEASE, REPORT.
- IDLE:
  - id_word_ready = (count<NWORDS) && !start.
  - An accepted word is written at slot count, then count increments. count saturates at NWORDS.
  - start has priority over a same-cycle word: the word is not accepted.
- start in IDLE with count<NWORDS -> REPORT, status INCOMPLETE. No request issued.
- start in IDLE with lc_state>=LC_EOL (5) -> REPORT, status EOL. No request issued.
- Otherwise on start:
  - capture pre_state=lc_state; clear timer; go to REQUEST.
  - lc_transition_request rises on the next cycle.
- lc_identifier equals the buffer only while in REQUEST; it is 0 in every other state.
- REQUEST: request=1; timer increments each cycle. On lc_done=1, capture lc_success and go to RELEASE (request=0 the following cycle).
- RELEASE: request=0; timer continues. Move to REPORT when lc_done=0. Status is computed as:
  - success && lc_state==pre_state+1 -> OK
  - success && lc_state!=pre_state+1 -> STATE_MISMATCH
  - !success -> REJECTED
- Timeout: timer==TIMEOUT_CYCLES in REQUEST or RELEASE -> REPORT with status TIMEOUT; request drops the next cycle.
- REPORT (exactly one cycle): cmd_done=1; buffer cleared to 0; count=0; then IDLE.
- start outside IDLE is ignored. Words are never accepted outside IDLE.
- Minimum latency, start to cmd_done, when the responder answers immediately: 1 (request) + responder auth + 1 (release) + responder drop + 1 (report) cycles.
- Status encoding: 0 NONE, 1 OK, 2 REJECTED, 3 TIMEOUT, 4 INCOMPLETE, 5 EOL, 6 STATE_MISMATCH.
- Timer width is $clog2(TIMEOUT_CYCLES+1) and it saturates; it cannot wrap.
- Reset mid-transaction drops the request asynchronously and zeroizes the buffer. No cmd_done is produced.
- lc_done already high on entry to REQUEST (stale handshake) is treated as completion with the sampled lc_success. The state check catches a bogus success.

Decomposition:
- Package lc_pkg holds:
  - lc_status_t enum (the codes above)
  - LC_RESET_STATE=3'b001, LC_EOL=3'd5, LC_STATE_W=3
  - the initiator FSM state typedef
- Sub-module lc_id_assembler holds the word counter, buffer write, saturation, and synchronous clear. Ports: clk, rst_n, wr_valid, wr_ready, wr_data, clear, full, id.

Test Plan:
- Load 8 words 0x00000001..0x00000008, start; responder matches with lc_state 1->2 -> request held until lc_done; identifier = 0x00000008_..._00000001; cmd_status=OK (1); buffer reads 0 after cmd_done.
- Wrong identifier loaded; responder returns done with success=0 -> cmd_status=REJECTED (2); lc_state unchanged; request low before responder drops done.
- 5 words loaded, then start -> next cycle cmd_done=1, status=INCOMPLETE (4), request never asserted, count reset to 0.
- lc_state=5 with full buffer, start -> status=EOL (5), no request.
- Responder never asserts lc_done, TIMEOUT_CYCLES=16 -> request high exactly 16 cycles, then drops; status=TIMEOUT (3).
- Assert rst_n=0 mid-REQUEST -> request and identifier go to 0 immediately; no cmd_done. A word presented in the same cycle as start is not accepted (ready=0).
